// File: rtl/ex_md_pkg.sv
// ex_md_pkg: shared encodings and small decode helpers for the EX-stage
// iterative multiply/divide unit.
package ex_md_pkg;

    // Operation encodings presented on md_i_op
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // Bit 1 of the opcode separates divides from multiplies
    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // Bit 0 clear means the operands are two's-complement
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_md_div_step.sv
// ex_md_div_step: one combinational restoring-division step. The partial
// remainder is shifted left by one with the next dividend bit appended, and
// the divisor is subtracted back out only when it fits.
module ex_md_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_next,
    output logic              quo_bit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;

    // One extra top bit on the trial subtraction exposes the borrow, which
    // is exactly "divisor did not fit"
    always_comb begin
        shifted  = {rem, dividend_bit};
        trial    = shifted - {2'b00, divisor};
        quo_bit  = ~trial[DATA_W+1];
        rem_next = quo_bit ? trial[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit for the EX stage.
// Runs MULT/MULTU/DIV/DIVU over DATA_W cycles, holds busy while iterating and
// presents the HI/LO pair with a one-cycle done pulse.
// Optional build macro EX_MD_EARLY_EXIT_EN: multiplies stop as soon as the
// remaining partial products are known to be zero.
module ex_muldiv
    import ex_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              md_i_start,
    input  logic [1:0]        md_i_op,
    input  logic [DATA_W-1:0] md_i_opa,
    input  logic [DATA_W-1:0] md_i_opb,
    input  logic              md_i_cancel,
    output logic              md_o_busy,
    output logic              md_o_done,
    output logic [DATA_W-1:0] md_o_hi,
    output logic [DATA_W-1:0] md_o_lo,
    output logic              md_o_div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    md_state_e           state;
    logic [1:0]          op;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W:0]     rem_q;
    logic [DATA_W-1:0]   quo;
    logic                res_neg;
    logic                rem_neg;
    logic                dbz_q;
    logic [DATA_W-1:0]   out_hi;
    logic [DATA_W-1:0]   out_lo;
    logic                out_dbz;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] acc_next;
    logic [DATA_W:0]     rem_step;
    logic                quo_bit;
    logic                mul_exit;
    logic [2*DATA_W-1:0] prod_aligned;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   remd;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;
    logic                res_dbz;
    logic                show;

    // Signed operands are converted to magnitudes before iterating; the
    // most-negative value maps to its own bit pattern, which is the correct
    // unsigned magnitude
    always_comb begin
        a_neg = is_signed_op(md_i_op) & md_i_opa[DATA_W-1];
        b_neg = is_signed_op(md_i_op) & md_i_opb[DATA_W-1];
        a_mag = a_neg ? -md_i_opa : md_i_opa;
        b_mag = b_neg ? -md_i_opb : md_i_opb;
    end

    // Shift-add multiply step: add the multiplicand into the upper half when
    // the current multiplier bit is set, then shift the whole accumulator right
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        acc_next = {mul_sum, acc[DATA_W-1:1]};
    end

    ex_md_div_step #(
        .DATA_W(DATA_W)
    ) u_div_step (
        .rem          (rem_q),
        .dividend_bit (quo[DATA_W-1]),
        .divisor      (mag_b),
        .rem_next     (rem_step),
        .quo_bit      (quo_bit)
    );

`ifdef EX_MD_EARLY_EXIT_EN
    logic [CNT_W-1:0] shamt;

    // A multiply can stop once no set multiplier bits remain after this step
    // or the multiplicand is zero; the accumulator is then short of its final
    // alignment by the number of skipped steps
    always_comb begin
        mul_exit = ~is_div(op) & ((mag_b[DATA_W-1:1] == '0) | (mag_a == '0));
        shamt    = CNT_W'(DATA_W) - cnt;
    end
`else
    // Fixed-length multiply: no early termination
    always_comb begin
        mul_exit = 1'b0;
    end
`endif

    // Sign correction and result selection, valid while in DONE
    always_comb begin
        prod_aligned = acc;
`ifdef EX_MD_EARLY_EXIT_EN
        prod_aligned = acc >> shamt;
`endif
        prod = res_neg ? -prod_aligned : prod_aligned;
        quot = res_neg ? -quo : quo;
        remd = rem_neg ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
        if (dbz_q) begin
            res_hi  = quo;
            res_lo  = '1;
            res_dbz = 1'b1;
        end else if (is_div(op)) begin
            res_hi  = remd;
            res_lo  = quot;
            res_dbz = 1'b0;
        end else begin
            res_hi  = prod[2*DATA_W-1:DATA_W];
            res_lo  = prod[DATA_W-1:0];
            res_dbz = 1'b0;
        end
    end

    // The new result is presented only during a DONE cycle that is not being
    // flushed; otherwise the last committed result is held
    always_comb begin
        show             = (state == DONE) & ~md_i_cancel;
        md_o_busy        = (state == CALC);
        md_o_done        = show;
        md_o_hi          = show ? res_hi  : out_hi;
        md_o_lo          = show ? res_lo  : out_lo;
        md_o_div_by_zero = show ? res_dbz : out_dbz;
    end

    // Sequencer: accept in IDLE, iterate in CALC, commit the result in DONE
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            op      <= 2'b00;
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            rem_q   <= '0;
            quo     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dbz_q   <= 1'b0;
            out_hi  <= '0;
            out_lo  <= '0;
            out_dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_i_start && !md_i_cancel) begin
                        op      <= md_i_op;
                        cnt     <= '0;
                        mag_a   <= a_mag;
                        mag_b   <= b_mag;
                        acc     <= '0;
                        rem_q   <= '0;
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg & (md_i_op == MD_DIV);
                        if (is_div(md_i_op) && (md_i_opb == '0)) begin
                            dbz_q <= 1'b1;
                            quo   <= md_i_opa;
                            state <= DONE;
                        end else begin
                            dbz_q <= 1'b0;
                            quo   <= a_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (md_i_cancel) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (is_div(op)) begin
                            rem_q <= rem_step;
                            quo   <= {quo[DATA_W-2:0], quo_bit};
                        end else begin
                            acc   <= acc_next;
                            mag_b <= mag_b >> 1;
                        end
                        if ((cnt == LAST_STEP) || mul_exit) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!md_i_cancel) begin
                        out_hi  <= res_hi;
                        out_lo  <= res_lo;
                        out_dbz <= res_dbz;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and random checks of ex_muldiv (DATA_W=32) against
// a plain-arithmetic reference model.
module tb_ex_muldiv;
    import ex_md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_;
    logic         start;
    logic [1:0]   op_sel;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    int tests_run = 0;
    int fails     = 0;

    ex_muldiv #(
        .DATA_W(W)
    ) dut (
        .clk              (clk),
        .rst_             (rst_),
        .md_i_start       (start),
        .md_i_op          (op_sel),
        .md_i_opa         (opa),
        .md_i_opb         (opb),
        .md_i_cancel      (cancel),
        .md_o_busy        (busy),
        .md_o_done        (done),
        .md_o_hi          (hi),
        .md_o_lo          (lo),
        .md_o_div_by_zero (dbz)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from integer arithmetic, latency from the
    // documented cycle counts
    function automatic void ref_model(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] e_hi, output logic [W-1:0] e_lo,
                                      output logic e_dbz, output int lat);
        longint      sa, sb, q, r, ma, mb;
        logic [63:0] p;
        int          bits;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e_dbz = 1'b0;
        lat   = W + 1;
        p     = '0;
        q     = 0;
        r     = 0;
        if ((op == MD_DIV || op == MD_DIVU) && b == '0) begin
            e_hi  = a;
            e_lo  = '1;
            e_dbz = 1'b1;
            lat   = 1;
        end else if (op == MD_MULT || op == MD_MULTU) begin
            if (op == MD_MULT) p = sa * sb;
            else               p = {32'h0, a} * {32'h0, b};
            e_hi = p[63:32];
            e_lo = p[31:0];
`ifdef EX_MD_EARLY_EXIT_EN
            ma = (op == MD_MULT) ? ((sa < 0) ? -sa : sa) : longint'({32'h0, a});
            mb = (op == MD_MULT) ? ((sb < 0) ? -sb : sb) : longint'({32'h0, b});
            bits = 0;
            while (bits < 64 && (mb >> bits) != 0) bits++;
            lat = (ma == 0 || mb == 0) ? 2 : bits + 1;
`else
            ma = 0;
            mb = 0;
            bits = 0;
`endif
        end else begin
            if (op == MD_DIV) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'({32'h0, a}) / longint'({32'h0, b});
                r = longint'({32'h0, a}) % longint'({32'h0, b});
            end
            e_hi = r[31:0];
            e_lo = q[31:0];
        end
    endfunction

    // Issue one operation and watch it until done or the cycle budget runs out
    task automatic apply_stimulus(input md_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic inject_start,
                                  output int done_at, output int busy_cycles,
                                  output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output logic r_dbz);
        @(negedge clk);
        start  = 1'b1;
        op_sel = op;
        opa    = a;
        opb    = b;
        @(posedge clk);
        #1 start = 1'b0;
        done_at     = 0;
        busy_cycles = 0;
        r_hi  = 'x;
        r_lo  = 'x;
        r_dbz = 1'bx;
        for (int k = 1; k <= W + 4 && done_at == 0; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_at = k;
                r_hi    = hi;
                r_lo    = lo;
                r_dbz   = dbz;
            end
            if (inject_start && k == 3) begin
                start  = 1'b1;
                op_sel = MD_MULTU;
                opa    = ~a;
                opb    = b + 1;
            end
            if (k == 4) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input md_op_e op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic inject_start);
        logic [W-1:0] e_hi, e_lo, r_hi, r_lo;
        logic         e_dbz, r_dbz;
        int           lat, done_at, busy_cycles;
        ref_model(op, a, b, e_hi, e_lo, e_dbz, lat);
        apply_stimulus(op, a, b, inject_start, done_at, busy_cycles, r_hi, r_lo, r_dbz);
        check_output({tag, ".latency"}, 64'(done_at), 64'(lat));
        check_output({tag, ".busy_cycles"}, 64'(busy_cycles), 64'(lat - 1));
        check_output({tag, ".hi"}, 64'(r_hi), 64'(e_hi));
        check_output({tag, ".lo"}, 64'(r_lo), 64'(e_lo));
        check_output({tag, ".dbz"}, 64'(r_dbz), 64'(e_dbz));
        @(negedge clk);
        check_output({tag, ".done_pulse"}, 64'(done), 64'(0));
        check_output({tag, ".hold"}, {hi, lo}, {e_hi, e_lo});
    endtask

    logic [W-1:0] prev_hi, prev_lo;
    md_op_e       rop;
    logic [W-1:0] ra, rb;
    int           sel;

    initial begin
        rst_   = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op_sel = MD_MULT;
        opa    = '0;
        opb    = '0;
        #1 rst_ = 1'b0;
        #10;
        check_output("reset.flags", {61'h0, busy, done, dbz}, 64'h0);
        check_output("reset.hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        check_output("post_reset.idle", {61'h0, busy, done, dbz}, 64'h0);

        run_and_check("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_and_check("mult_neg3x7", MD_MULT, -32'sd3, 32'd7, 1'b0);
        run_and_check("mult_0x5", MD_MULT, 32'd0, 32'd5, 1'b0);
        run_and_check("div_neg7by2", MD_DIV, -32'sd7, 32'd2, 1'b0);
        run_and_check("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_and_check("divu_100by7", MD_DIVU, 32'd100, 32'd7, 1'b0);
        run_and_check("divu_by0", MD_DIVU, 32'd100, 32'd0, 1'b0);
        run_and_check("divu_9by3", MD_DIVU, 32'd9, 32'd3, 1'b0);
        run_and_check("div_neg_by0", MD_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);

        // Flush in the tenth CALC cycle of a divide
        prev_hi = hi;
        prev_lo = lo;
        @(negedge clk);
        start  = 1'b1;
        op_sel = MD_DIV;
        opa    = 32'd1000;
        opb    = 32'd13;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check_output("cancel.busy_before", 64'(busy), 64'(1));
        cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check_output("cancel.busy_after", 64'(busy), 64'(0));
        check_output("cancel.no_done", 64'(done), 64'(0));
        check_output("cancel.hold", {hi, lo}, {prev_hi, prev_lo});
        run_and_check("after_cancel_div", MD_DIV, -32'sd1000, 32'd13, 1'b1);

        // Start and cancel together in IDLE: nothing may start
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op_sel = MD_MULTU;
        opa    = 32'd5;
        opb    = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check_output("start_cancel.idle", {62'h0, busy, done}, 64'h0);

        // Random operations against the model
        for (int i = 0; i < 24; i++) begin
            rop = md_op_e'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            ra  = (sel < 3) ? W'($signed($urandom_range(0, 40)) - 20) : W'($urandom);
            sel = $urandom_range(0, 9);
            rb  = (sel == 0) ? '0 : (sel < 4) ? W'($urandom_range(1, 20)) : W'($urandom);
            run_and_check($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
        end

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start  = 1'b1;
        op_sel = MD_MULTU;
        opa    = 32'hFFFF_FFFF;
        opb    = 32'h1234_5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_ = 1'b0;
        #1;
        check_output("async_reset.flags", {61'h0, busy, done, dbz}, 64'h0);
        check_output("async_reset.hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst_ = 1'b1;
        run_and_check("multu_2x3", MD_MULTU, 32'd2, 32'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
